fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000000, meaning the bubble instruction emitted when no valid fetch occurs.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_addr  output  32  instruction-memory address; equals PC.
REQ-006 SHALL have port imem_data  input  32  instruction word, combinationally returned for imem_addr.
REQ-007 SHALL have port hazard  input  1  decode-side RAW hazard against the instruction being fetched.
REQ-008 SHALL have port hazard_cycles  input  2  bubble count requested with hazard; 0 means no stall.
REQ-009 SHALL have port branch_taken  input  1  redirect request.
REQ-010 SHALL have port branch_target  input  32  redirect address.
REQ-011 SHALL have port PCAdd4  output  32  PC+4 of the current fetch, feeding the IF/ID register.
REQ-012 SHALL have port Inst  output  32  fetched instruction or NOP_INST, feeding the IF/ID register.
REQ-013 SHALL have port fetch_valid  output  1  high when Inst is a real fetch.
REQ-014 SHALL have port fetch_count  output  32  number of valid fetches since reset.

Function
REQ-015 SHALL hold state register with states RUN and STALL, a 2-bit bubble counter cnt, a 32-bit PC, and fetch_count.
REQ-016 SHALL drive imem_addr, PCAdd4 (= PC+4 mod 2^32), Inst and fetch_valid combinationally from registers and inputs, with zero-cycle latency.
REQ-017 SHALL use event priority rst > branch_taken > hazard > normal fetch.
REQ-018 In RUN with no event, SHALL emit Inst=imem_data and fetch_valid=1, then set PC<=PC+4 and increment fetch_count.
REQ-019 On branch_taken in either state, SHALL emit Inst=NOP_INST and fetch_valid=0, set PC<=branch_target with bits [1:0] forced to 00, set cnt<=0, and set next state RUN.
REQ-020 In RUN on hazard with hazard_cycles=N>0, SHALL emit a bubble and hold PC; if N=1, the next state SHALL be RUN; otherwise cnt<=N-1 and the next state SHALL be STALL.
REQ-021 In RUN on hazard with hazard_cycles=0, SHALL behave as a normal fetch.
REQ-022 In STALL, SHALL emit a bubble, hold PC, and decrement cnt; when cnt=1, the next state SHALL be RUN.
REQ-023 In STALL, SHALL ignore hazard.
REQ-024 SHALL produce exactly N bubbles for a hazard of N cycles, and SHALL refetch the held PC afterwards.
REQ-025 SHALL wrap PC from 32'hFFFFFFFC to 32'h00000000 with PCAdd4 = 0 at that point.
REQ-026 SHALL wrap fetch_count from 32'hFFFFFFFF to 0.
REQ-027 SHALL NOT increment fetch_count during a bubble cycle.

Reset
REQ-028 While rst is high, SHALL emit Inst=NOP_INST and fetch_valid=0.
REQ-029 At the clock edge with rst high, SHALL set PC<=RESET_PC, state<=RUN, cnt<=0 and fetch_count<=0, including mid-STALL.
REQ-030 In the first cycle after rst deasserts, SHALL drive imem_addr=RESET_PC and PCAdd4=RESET_PC+4.

Structure
REQ-031 SHALL place the state encoding (RUN, STALL), the NOP_INST default and the RESET_PC default in shared package fetch_pkg.
REQ-032 SHALL implement cnt load/decrement in one sub-module, fetch_stall_ctr, with inputs load, load_val[1:0], dec and output last.
REQ-033 SHALL keep the PC register and next-PC mux in fetch_unit.

Verification
REQ-034 Bench SHALL cover reset then 4 cycles with imem returning 32'h11111111..44444444: imem_addr 0,4,8,C; PCAdd4 4,8,C,10; fetch_count=4.
REQ-035 Bench SHALL cover hazard=1, hazard_cycles=3 at PC=8: 3 NOP cycles with imem_addr=8, then valid fetch at 8, fetch_count unchanged during bubbles.
REQ-036 Bench SHALL cover branch_taken with target 32'h00000103 during STALL cycle 2: bubble that cycle, next imem_addr=32'h00000100, state RUN.
REQ-037 Bench SHALL cover simultaneous hazard (hazard_cycles=2) and branch_taken (target 0x40) in RUN: one bubble, next PC=0x40, no stall.
REQ-038 Bench SHALL cover RESET_PC=32'hFFFFFFFC: first PCAdd4=0, next imem_addr=0.
REQ-039 Bench SHALL cover rst asserted mid-STALL with cnt=2: next cycle PC=RESET_PC, state RUN, fetch_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: FSM state encoding,
// bubble-counter type, default reset PC / bubble instruction, and a helper
// that word-aligns an address.
// -----------------------------------------------------------------------------
package fetch_pkg;

   // Fetch FSM: RUN fetches (or takes a one-cycle bubble), STALL burns the
   // remaining bubbles of a multi-cycle hazard.
   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } fetch_state_e;

   // Remaining-bubble counter; hazard_cycles is 2 bits wide, so is this.
   typedef logic [1:0] stall_cnt_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;
   localparam logic [31:0] INST_BYTES       = 32'd4;

   // Instructions are word aligned, so redirect targets drop their low bits.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage : fetch_pkg

// File: rtl/fetch_stall_ctr.sv
// -----------------------------------------------------------------------------
// fetch_stall_ctr
// Bubble counter used by the fetch FSM while stalled on a hazard.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears the count
//   load      load load_val into the counter (wins over dec)
//   load_val  value to load (remaining bubbles after the current one)
//   dec       decrement the counter by one (saturates at zero)
//   last      high when exactly one bubble remains
// -----------------------------------------------------------------------------
module fetch_stall_ctr
   import fetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [1:0] load_val,
   input  logic       dec,
   output logic       last
);

   stall_cnt_t cnt;

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values of its sources, regardless of the
   // order in which the simulator evaluates always_ff blocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 2'd1;
      end
   end

   assign last = (cnt == 2'd1);

endmodule : fetch_stall_ctr

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, drives the instruction-memory address,
// and hands PC+4 plus the fetched word (or a bubble) to the IF/ID register.
// Redirects and decode-side hazards are handled here with priority
// rst > branch_taken > hazard > normal fetch.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   NOP_INST  bubble instruction emitted when no valid fetch occurs
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   imem_addr      instruction-memory address (= PC)
//   imem_data      instruction word returned combinationally for imem_addr
//   hazard         RAW hazard against the instruction being fetched
//   hazard_cycles  bubbles requested with hazard (0 = no stall)
//   branch_taken   redirect request
//   branch_target  redirect address (low two bits ignored)
//   PCAdd4         PC + 4 of the current fetch
//   Inst           fetched instruction or NOP_INST
//   fetch_valid    high when Inst is a real fetch
//   fetch_count    number of valid fetches since reset (wraps)
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        hazard,
   input  logic [1:0]  hazard_cycles,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] PCAdd4,
   output logic [31:0] Inst,
   output logic        fetch_valid,
   output logic [31:0] fetch_count
);

   fetch_state_e state, next_state;
   logic [31:0]  pc, pc_next;
   logic         ctr_load, ctr_dec, ctr_last;
   logic [1:0]   ctr_load_val;

   fetch_stall_ctr u_stall_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (ctr_load),
      .load_val (ctr_load_val),
      .dec      (ctr_dec),
      .last     (ctr_last)
   );

   // Address and PC+4 come straight from the PC register; the adder wraps
   // naturally at 2^32.
   assign imem_addr = pc;
   assign PCAdd4    = pc + INST_BYTES;

   // NOTE: every signal driven here gets a default before any branching, so
   // no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      next_state   = state;
      pc_next      = pc;
      Inst         = NOP_INST;
      fetch_valid  = 1'b0;
      ctr_load     = 1'b0;
      ctr_load_val = 2'd0;
      ctr_dec      = 1'b0;

      // While rst is high the defaults (bubble, hold) apply; the register
      // block overrides state, PC and count at the edge.
      if (!rst) begin
         if (branch_taken) begin
            // Redirect squashes whatever is fetched this cycle and cancels
            // any stall still in progress.
            pc_next      = align_word(branch_target);
            ctr_load     = 1'b1;
            ctr_load_val = 2'd0;
            next_state   = RUN;
         end else begin
            unique case (state)
               RUN: begin
                  if (hazard && (hazard_cycles != 2'd0)) begin
                     // This cycle is the first bubble; STALL covers the rest.
                     if (hazard_cycles != 2'd1) begin
                        ctr_load     = 1'b1;
                        ctr_load_val = hazard_cycles - 2'd1;
                        next_state   = STALL;
                     end
                  end else begin
                     Inst        = imem_data;
                     fetch_valid = 1'b1;
                     pc_next     = pc + INST_BYTES;
                  end
               end
               STALL: begin
                  // Hazard input is not re-examined while stalling.
                  ctr_dec = 1'b1;
                  if (ctr_last) begin
                     next_state = RUN;
                  end
               end
               default: next_state = RUN;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         pc          <= RESET_PC;
         fetch_count <= '0;
      end else begin
         state <= next_state;
         pc    <= pc_next;
         if (fetch_valid) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Two instances: the main one (RESET_PC=0,
// distinctive NOP) and one that resets to the top word to exercise PC wrap.
// A behavioural model tracks PC, outstanding bubbles and the fetch count.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] TOP_PC  = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst;
   logic        hazard;
   logic [1:0]  hazard_cycles;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr, imem_data, PCAdd4, Inst, fetch_count;
   logic        fetch_valid;

   logic [31:0] w_imem_addr, w_imem_data, w_PCAdd4, w_Inst, w_count;
   logic        w_valid;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [31:0] m_pc;
   logic [31:0] m_count;
   int          m_bub = 0;

   always #5 clk = ~clk;

   // Instruction memory contents: 0x11111111..0x44444444 in the first four
   // words, an address-derived pattern elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd16) return 32'h1111_1111 * ((a >> 2) + 32'd1);
      return {a[15:0], ~a[31:16]};
   endfunction

   assign imem_data   = mem_word(imem_addr);
   assign w_imem_data = mem_word(w_imem_addr);

   fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .hazard        (hazard),
      .hazard_cycles (hazard_cycles),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .PCAdd4        (PCAdd4),
      .Inst          (Inst),
      .fetch_valid   (fetch_valid),
      .fetch_count   (fetch_count)
   );

   fetch_unit #(.RESET_PC(TOP_PC)) dut_wrap (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (w_imem_addr),
      .imem_data     (w_imem_data),
      .hazard        (1'b0),
      .hazard_cycles (2'd0),
      .branch_taken  (1'b0),
      .branch_target (32'h0),
      .PCAdd4        (w_PCAdd4),
      .Inst          (w_Inst),
      .fetch_valid   (w_valid),
      .fetch_count   (w_count)
   );

   // Model: a hazard of N cycles means N bubbles in total, a branch cancels
   // any outstanding bubbles, reset restarts everything.
   always @(posedge clk) begin
      if (rst) begin
         m_pc    <= 32'h0;
         m_bub   <= 0;
         m_count <= 32'h0;
      end else if (branch_taken) begin
         m_pc  <= branch_target & ~32'd3;
         m_bub <= 0;
      end else if (m_bub > 0) begin
         m_bub <= m_bub - 1;
      end else if (hazard && hazard_cycles != 2'd0) begin
         m_bub <= int'(hazard_cycles) - 1;
      end else begin
         m_pc    <= m_pc + 32'd4;
         m_count <= m_count + 32'd1;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_idle();
      rst = 1'b0; hazard = 1'b0; hazard_cycles = 2'd0;
      branch_taken = 1'b0; branch_target = 32'h0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1; hazard = 1'b1; hazard_cycles = 2'd2;
      branch_taken = 1'b1; branch_target = 32'h200;
      #1;
      checks++; if (Inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h expected %h", Inst, NOP); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", fetch_valid); end
      next_cycle();
      next_cycle();
      #1;
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", imem_addr); end
      checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", fetch_count); end
      checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_wrap_valid: got %b expected 0", w_valid); end
      drive_idle();
      #1;
      checks++; if (PCAdd4 !== 32'h4) begin errors++; $display("FAIL reset_pcadd4: got %h expected 00000004", PCAdd4); end
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b expected 1", fetch_valid); end
      next_cycle();
   endtask

   task automatic test_sequential();
      logic [31:0] exp_inst;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         exp_inst = 32'h1111_1111 * (i + 1);
         #1;
         checks++; if (imem_addr !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, 32'(i * 4)); end
         checks++; if (PCAdd4 !== 32'(i * 4 + 4)) begin errors++; $display("FAIL seq_pcadd4[%0d]: got %h expected %h", i, PCAdd4, 32'(i * 4 + 4)); end
         checks++; if (Inst !== exp_inst) begin errors++; $display("FAIL seq_inst[%0d]: got %h expected %h", i, Inst, exp_inst); end
         checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, fetch_valid); end
         next_cycle();
      end
      #1;
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL seq_count: got %0d expected 4", fetch_count); end
   endtask

   task automatic test_hazard_stall();
      do_reset();
      next_cycle();
      next_cycle();
      // Hazard stays high through the stall; it must be ignored there.
      hazard = 1'b1; hazard_cycles = 2'd3;
      for (int b = 0; b < 3; b++) begin
         #1;
         checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL haz_addr[%0d]: got %h expected 00000008", b, imem_addr); end
         checks++; if (Inst !== NOP || fetch_valid !== 1'b0) begin errors++; $display("FAIL haz_bubble[%0d]: got inst %h valid %b expected %h 0", b, Inst, fetch_valid, NOP); end
         checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL haz_count[%0d]: got %0d expected 2", b, fetch_count); end
         next_cycle();
      end
      drive_idle();
      #1;
      checks++; if (imem_addr !== 32'h8 || fetch_valid !== 1'b1) begin errors++; $display("FAIL haz_refetch: got addr %h valid %b expected 00000008 1", imem_addr, fetch_valid); end
      checks++; if (Inst !== 32'h3333_3333) begin errors++; $display("FAIL haz_refetch_inst: got %h expected 33333333", Inst); end
      next_cycle();
      #1;
      checks++; if (fetch_count !== 32'd3 || imem_addr !== 32'hC) begin errors++; $display("FAIL haz_after: got count %0d addr %h expected 3 0000000c", fetch_count, imem_addr); end
   endtask

   task automatic test_branch_in_stall();
      do_reset();
      next_cycle();
      next_cycle();
      hazard = 1'b1; hazard_cycles = 2'd3;
      next_cycle();
      drive_idle();
      next_cycle();
      // Second cycle spent in STALL.
      branch_taken = 1'b1; branch_target = 32'h0000_0103;
      #1;
      checks++; if (Inst !== NOP || fetch_valid !== 1'b0) begin errors++; $display("FAIL bstall_bubble: got inst %h valid %b expected %h 0", Inst, fetch_valid, NOP); end
      next_cycle();
      drive_idle();
      #1;
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL bstall_target: got %h expected 00000100", imem_addr); end
      checks++; if (fetch_valid !== 1'b1 || Inst !== mem_word(32'h100)) begin errors++; $display("FAIL bstall_fetch: got inst %h valid %b expected %h 1", Inst, fetch_valid, mem_word(32'h100)); end
      next_cycle();
      #1;
      checks++; if (imem_addr !== 32'h104 || fetch_valid !== 1'b1) begin errors++; $display("FAIL bstall_run: got addr %h valid %b expected 00000104 1", imem_addr, fetch_valid); end
   endtask

   task automatic test_hazard_and_branch();
      do_reset();
      next_cycle();
      hazard = 1'b1; hazard_cycles = 2'd2;
      branch_taken = 1'b1; branch_target = 32'h40;
      #1;
      checks++; if (Inst !== NOP || fetch_valid !== 1'b0) begin errors++; $display("FAIL hb_bubble: got inst %h valid %b expected %h 0", Inst, fetch_valid, NOP); end
      next_cycle();
      drive_idle();
      #1;
      checks++; if (imem_addr !== 32'h40 || fetch_valid !== 1'b1) begin errors++; $display("FAIL hb_target: got addr %h valid %b expected 00000040 1", imem_addr, fetch_valid); end
      next_cycle();
      #1;
      checks++; if (imem_addr !== 32'h44 || fetch_valid !== 1'b1 || fetch_count !== 32'd2) begin errors++; $display("FAIL hb_nostall: got addr %h valid %b count %0d expected 00000044 1 2", imem_addr, fetch_valid, fetch_count); end
   endtask

   task automatic test_reset_pc_wrap();
      do_reset();
      #1;
      checks++; if (w_imem_addr !== TOP_PC) begin errors++; $display("FAIL wrap_addr: got %h expected %h", w_imem_addr, TOP_PC); end
      checks++; if (w_PCAdd4 !== 32'h0) begin errors++; $display("FAIL wrap_pcadd4: got %h expected 00000000", w_PCAdd4); end
      checks++; if (w_valid !== 1'b1 || w_Inst !== mem_word(TOP_PC)) begin errors++; $display("FAIL wrap_inst: got inst %h valid %b expected %h 1", w_Inst, w_valid, mem_word(TOP_PC)); end
      next_cycle();
      #1;
      checks++; if (w_imem_addr !== 32'h0 || w_PCAdd4 !== 32'h4) begin errors++; $display("FAIL wrap_next: got addr %h pcadd4 %h expected 00000000 00000004", w_imem_addr, w_PCAdd4); end
      checks++; if (w_count !== 32'd1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", w_count); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      next_cycle();
      hazard = 1'b1; hazard_cycles = 2'd3;
      next_cycle();
      // Now stalled with two bubbles left.
      drive_idle();
      rst = 1'b1;
      #1;
      checks++; if (Inst !== NOP || fetch_valid !== 1'b0) begin errors++; $display("FAIL rstall_bubble: got inst %h valid %b expected %h 0", Inst, fetch_valid, NOP); end
      next_cycle();
      rst = 1'b0;
      #1;
      checks++; if (imem_addr !== 32'h0 || PCAdd4 !== 32'h4) begin errors++; $display("FAIL rstall_pc: got addr %h pcadd4 %h expected 00000000 00000004", imem_addr, PCAdd4); end
      checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rstall_count: got %0d expected 0", fetch_count); end
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL rstall_run: got valid %b expected 1", fetch_valid); end
      next_cycle();
      #1;
      checks++; if (imem_addr !== 32'h4 || fetch_valid !== 1'b1 || fetch_count !== 32'd1) begin errors++; $display("FAIL rstall_after: got addr %h valid %b count %0d expected 00000004 1 1", imem_addr, fetch_valid, fetch_count); end
   endtask

   task automatic test_random();
      logic        exp_valid;
      logic [31:0] exp_inst;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rst           = ($urandom_range(0, 49) == 0);
         branch_taken  = ($urandom_range(0, 7) == 0);
         hazard        = ($urandom_range(0, 2) == 0);
         hazard_cycles = 2'($urandom_range(0, 3));
         branch_target = $urandom;
         if ($urandom_range(0, 3) == 0) branch_target = 32'hFFFF_FFF0 | (branch_target & 32'hF);
         #1;
         exp_valid = !rst && !branch_taken && (m_bub == 0) && !(hazard && hazard_cycles != 2'd0);
         exp_inst  = exp_valid ? mem_word(m_pc) : NOP;
         checks++;
         if ({imem_addr, PCAdd4, Inst, fetch_valid, fetch_count} !==
             {m_pc, m_pc + 32'd4, exp_inst, exp_valid, m_count}) begin
            errors++;
            $display("FAIL random[%0d]: got addr %h pcadd4 %h inst %h valid %b count %0d expected %h %h %h %b %0d",
                     n, imem_addr, PCAdd4, Inst, fetch_valid, fetch_count,
                     m_pc, m_pc + 32'd4, exp_inst, exp_valid, m_count);
         end
         next_cycle();
      end
      drive_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive_idle();
      @(negedge clk);
      test_reset();
      test_sequential();
      test_hazard_stall();
      test_branch_in_stall();
      test_hazard_and_branch();
      test_reset_pc_wrap();
      test_reset_mid_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fetch_unit
